// File: rtl/vc_queue_pkg.sv
// Shared constants and width helpers for the partitioned val/rdy queue family.
package vc_queue_pkg;

    localparam logic [1:0] VC_QUEUE_NORMAL = 2'b00;
    localparam logic [1:0] VC_QUEUE_PIPE   = 2'b01;
    localparam logic [1:0] VC_QUEUE_BYPASS = 2'b10;

    function automatic int vc_addr_nbits(input int num_msgs);
        return (num_msgs > 2) ? $clog2(num_msgs) : 1;
    endfunction

    // One extra bit so a channel's free count can reach p_num_msgs.
    function automatic int vc_slice_nbits(input int num_msgs);
        return vc_addr_nbits(num_msgs) + 1;
    endfunction

endpackage

// File: rtl/vc_partitioned_queue_chan_ctrl.sv
// Control for one channel partition: pointers, full flag, free count and the
// channel's own rdy/val terms, evaluated as if the ports addressed this channel.
module vc_partitioned_queue_chan_ctrl
    import vc_queue_pkg::*;
#(
    parameter logic [1:0] p_type     = VC_QUEUE_NORMAL,
    parameter int         p_num_msgs = 4,
    localparam int        c_addr_nbits = vc_addr_nbits(p_num_msgs),
    localparam int        c_cnt_nbits  = c_addr_nbits + 1
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enq_val,
    input  logic                    enq_sel,
    input  logic                    deq_rdy,
    input  logic                    deq_sel,
    input  logic                    flush_sel,
    output logic                    enq_rdy,
    output logic                    deq_val,
    output logic                    empty,
    output logic                    wr_en,
    output logic [c_addr_nbits-1:0] enq_ptr,
    output logic [c_addr_nbits-1:0] deq_ptr,
    output logic [c_cnt_nbits-1:0]  num_free
);
    localparam logic c_pipe = p_type[0];
    localparam logic c_byp  = p_type[1];

    logic                    full;
    logic                    active;
    logic                    do_enq;
    logic                    do_deq;
    logic                    do_bypass;
    logic                    upd_deq;
    logic [c_addr_nbits-1:0] enq_ptr_inc;
    logic [c_addr_nbits-1:0] deq_ptr_inc;

    assign active  = reset & ~flush_sel;
    assign empty   = ~full & (enq_ptr == deq_ptr);
    assign enq_rdy = active & (~full | (c_pipe & deq_sel & deq_rdy));
    assign deq_val = active & (~empty | (c_byp & enq_val & enq_sel));

    assign do_enq    = enq_sel & enq_val & enq_rdy;
    assign do_deq    = deq_sel & deq_rdy & deq_val;
    // A bypassed message goes straight from enq_msg to the consumer and never lands in storage.
    assign do_bypass = do_enq & do_deq & empty;
    assign wr_en     = do_enq & ~do_bypass;
    assign upd_deq   = do_deq & ~do_bypass;

    assign enq_ptr_inc = (enq_ptr == c_addr_nbits'(p_num_msgs - 1)) ? '0 : enq_ptr + 1'b1;
    assign deq_ptr_inc = (deq_ptr == c_addr_nbits'(p_num_msgs - 1)) ? '0 : deq_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset || flush_sel) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            full    <= 1'b0;
        end else begin
            if (wr_en)
                enq_ptr <= enq_ptr_inc;
            if (upd_deq)
                deq_ptr <= deq_ptr_inc;
            if (wr_en && !upd_deq && (enq_ptr_inc == deq_ptr))
                full <= 1'b1;
            else if (upd_deq && full && !wr_en)
                full <= 1'b0;
        end
    end

    always_comb begin
        num_free = '0;
        if (full)
            num_free = '0;
        else if (enq_ptr == deq_ptr)
            num_free = c_cnt_nbits'(p_num_msgs);
        else if (enq_ptr > deq_ptr)
            num_free = c_cnt_nbits'(p_num_msgs) - ({1'b0, enq_ptr} - {1'b0, deq_ptr});
        else
            num_free = {1'b0, deq_ptr} - {1'b0, enq_ptr};
    end

endmodule

// File: rtl/vc_partitioned_queue.sv
// Multi-channel val/rdy queue: isolated fixed-size partitions of one shared
// storage array, with channel-tagged enqueue, channel-selected dequeue and flush.
module vc_partitioned_queue
    import vc_queue_pkg::*;
#(
    parameter logic [1:0] p_type      = VC_QUEUE_NORMAL,
    parameter int         p_msg_nbits = 32,
    parameter int         p_num_msgs  = 4,
    parameter int         p_num_chans = 2,
    localparam int        c_addr_nbits = vc_addr_nbits(p_num_msgs),
    localparam int        c_chan_nbits = $clog2(p_num_chans)
)(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      enq_val,
    output logic                                      enq_rdy,
    input  logic [c_chan_nbits-1:0]                   enq_chan,
    input  logic [p_msg_nbits-1:0]                    enq_msg,
    input  logic [c_chan_nbits-1:0]                   deq_chan,
    output logic                                      deq_val,
    input  logic                                      deq_rdy,
    output logic [p_msg_nbits-1:0]                    deq_msg,
    input  logic                                      flush,
    input  logic [c_chan_nbits-1:0]                   flush_chan,
    output logic [p_num_chans*(c_addr_nbits+1)-1:0]   num_free_entries
);
    localparam int c_slice_nbits = vc_slice_nbits(p_num_msgs);
    localparam int c_dec_chans   = 1 << c_chan_nbits;
    localparam int c_depth       = p_num_chans * p_num_msgs;
    localparam int c_store_nbits = $clog2(c_depth);

    // Decoded vectors cover every encodable index; unused codes read as idle channels.
    logic [c_dec_chans-1:0]  rdy_vec;
    logic [c_dec_chans-1:0]  val_vec;
    logic [c_dec_chans-1:0]  empty_vec;
    logic [c_dec_chans-1:0]  wr_vec;
    logic [c_addr_nbits-1:0] enq_ptr_arr [c_dec_chans];
    logic [c_addr_nbits-1:0] deq_ptr_arr [c_dec_chans];

    logic [p_msg_nbits-1:0]   storage [c_depth];
    logic [c_store_nbits-1:0] wr_addr;
    logic [c_store_nbits-1:0] rd_addr;
    logic                     wr_en;

    for (genvar i = 0; i < c_dec_chans; i++) begin : g_chan
        if (i < p_num_chans) begin : g_live
            vc_partitioned_queue_chan_ctrl #(
                .p_type     (p_type),
                .p_num_msgs (p_num_msgs)
            ) u_ctrl (
                .clk       (clk),
                .reset     (reset),
                .enq_val   (enq_val),
                .enq_sel   (enq_chan == c_chan_nbits'(i)),
                .deq_rdy   (deq_rdy),
                .deq_sel   (deq_chan == c_chan_nbits'(i)),
                .flush_sel (flush && (flush_chan == c_chan_nbits'(i))),
                .enq_rdy   (rdy_vec[i]),
                .deq_val   (val_vec[i]),
                .empty     (empty_vec[i]),
                .wr_en     (wr_vec[i]),
                .enq_ptr   (enq_ptr_arr[i]),
                .deq_ptr   (deq_ptr_arr[i]),
                .num_free  (num_free_entries[i*c_slice_nbits +: c_slice_nbits])
            );
        end else begin : g_pad
            assign rdy_vec[i]     = 1'b0;
            assign val_vec[i]     = 1'b0;
            assign empty_vec[i]   = 1'b1;
            assign wr_vec[i]      = 1'b0;
            assign enq_ptr_arr[i] = '0;
            assign deq_ptr_arr[i] = '0;
        end
    end

    assign enq_rdy = rdy_vec[enq_chan];
    assign deq_val = val_vec[deq_chan];
    assign wr_en   = wr_vec[enq_chan];

    assign wr_addr = c_store_nbits'(enq_chan) * c_store_nbits'(p_num_msgs)
                   + c_store_nbits'(enq_ptr_arr[enq_chan]);
    assign rd_addr = c_store_nbits'(deq_chan) * c_store_nbits'(p_num_msgs)
                   + c_store_nbits'(deq_ptr_arr[deq_chan]);

    always_ff @(posedge clk) begin
        if (wr_en)
            storage[wr_addr] <= enq_msg;
    end

    // An empty channel can only be valid through bypass, so its head is the incoming message.
    always_comb begin
        deq_msg = '0;
        if (deq_val)
            deq_msg = empty_vec[deq_chan] ? enq_msg : storage[rd_addr];
    end

endmodule

// File: tb/tb_vc_partitioned_queue.sv
// Bench for vc_partitioned_queue: three configurations share one stimulus stream and
// are compared against per-channel message queues plus directed vectors.
module tb_vc_partitioned_queue;
    import vc_queue_pkg::*;

    localparam int NCH = 3;
    localparam int ND  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enq_val = 1'b0;
    logic [1:0]  enq_chan = '0;
    logic [31:0] enq_msg = '0;
    logic [1:0]  deq_chan = '0;
    logic        deq_rdy = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  flush_chan = '0;

    logic [ND-1:0]       rdy_o;
    logic [ND-1:0]       val_o;
    logic [ND-1:0][31:0] msg_o;
    logic [ND-1:0][8:0]  free_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // d0: NORMAL depth 4, d1: PIPE|BYPASS depth 4, d2: NORMAL depth 3
    vc_partitioned_queue #(.p_type(VC_QUEUE_NORMAL), .p_msg_nbits(32), .p_num_msgs(4), .p_num_chans(NCH)) u_d0 (
        .clk(clk), .reset(reset), .enq_val(enq_val), .enq_rdy(rdy_o[0]), .enq_chan(enq_chan),
        .enq_msg(enq_msg), .deq_chan(deq_chan), .deq_val(val_o[0]), .deq_rdy(deq_rdy),
        .deq_msg(msg_o[0]), .flush(flush), .flush_chan(flush_chan), .num_free_entries(free_o[0]));
    vc_partitioned_queue #(.p_type(VC_QUEUE_PIPE | VC_QUEUE_BYPASS), .p_msg_nbits(32), .p_num_msgs(4), .p_num_chans(NCH)) u_d1 (
        .clk(clk), .reset(reset), .enq_val(enq_val), .enq_rdy(rdy_o[1]), .enq_chan(enq_chan),
        .enq_msg(enq_msg), .deq_chan(deq_chan), .deq_val(val_o[1]), .deq_rdy(deq_rdy),
        .deq_msg(msg_o[1]), .flush(flush), .flush_chan(flush_chan), .num_free_entries(free_o[1]));
    vc_partitioned_queue #(.p_type(VC_QUEUE_NORMAL), .p_msg_nbits(32), .p_num_msgs(3), .p_num_chans(NCH)) u_d2 (
        .clk(clk), .reset(reset), .enq_val(enq_val), .enq_rdy(rdy_o[2]), .enq_chan(enq_chan),
        .enq_msg(enq_msg), .deq_chan(deq_chan), .deq_val(val_o[2]), .deq_rdy(deq_rdy),
        .deq_msg(msg_o[2]), .flush(flush), .flush_chan(flush_chan), .num_free_entries(free_o[2]));

    // Reference: one FIFO of messages per (configuration, channel)
    logic [31:0] mq [ND*NCH][$];

    function automatic int depth_of(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic bit is_pipe(input int d);
        return d == 1;
    endfunction

    function automatic bit is_byp(input int d);
        return d == 1;
    endfunction

    function automatic bit m_fl(input int c);
        return flush && (int'(flush_chan) == c);
    endfunction

    function automatic bit m_rdy(input int d);
        int c;
        c = int'(enq_chan);
        if (!reset || c >= NCH || m_fl(c)) return 1'b0;
        if (mq[d*NCH+c].size() < depth_of(d)) return 1'b1;
        return is_pipe(d) && deq_rdy && (deq_chan == enq_chan);
    endfunction

    function automatic bit m_val(input int d);
        int c;
        c = int'(deq_chan);
        if (!reset || c >= NCH || m_fl(c)) return 1'b0;
        if (mq[d*NCH+c].size() > 0) return 1'b1;
        return is_byp(d) && enq_val && (enq_chan == deq_chan);
    endfunction

    function automatic logic [31:0] m_msg(input int d);
        int c;
        c = int'(deq_chan);
        if (!m_val(d)) return 32'h0;
        if (mq[d*NCH+c].size() == 0) return enq_msg;
        return mq[d*NCH+c][0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fr(input int d, input int c);
        return 32'(free_o[d][c*3 +: 3]);
    endfunction

    task automatic model_check();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("enq_rdy d%0d", d), 32'(rdy_o[d]), 32'(m_rdy(d)));
            chk($sformatf("deq_val d%0d", d), 32'(val_o[d]), 32'(m_val(d)));
            chk($sformatf("deq_msg d%0d", d), msg_o[d], m_msg(d));
            for (int c = 0; c < NCH; c++)
                chk($sformatf("free d%0d ch%0d", d, c), fr(d, c), 32'(depth_of(d) - mq[d*NCH+c].size()));
        end
    endtask

    task automatic model_update();
        for (int d = 0; d < ND; d++) begin
            bit de, dd;
            int ec, dc;
            ec = int'(enq_chan);
            dc = int'(deq_chan);
            de = enq_val && m_rdy(d);
            dd = deq_rdy && m_val(d);
            if (!reset) begin
                for (int c = 0; c < NCH; c++) mq[d*NCH+c].delete();
            end else begin
                if (flush && int'(flush_chan) < NCH) mq[d*NCH+int'(flush_chan)].delete();
                if (!(de && dd && ec == dc && mq[d*NCH+dc].size() == 0)) begin
                    if (dd) void'(mq[d*NCH+dc].pop_front());
                    if (de) mq[d*NCH+ec].push_back(enq_msg);
                end
            end
        end
    endtask

    task automatic tick();
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ev, input logic [1:0] ec, input logic [31:0] em,
                          input logic [1:0] dc, input logic dr, input logic fl, input logic [1:0] fc);
        enq_val = ev; enq_chan = ec; enq_msg = em;
        deq_chan = dc; deq_rdy = dr; flush = fl; flush_chan = fc;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    typedef struct {
        logic        rst;
        logic        ev;
        logic [1:0]  ec;
        logic [31:0] em;
        logic [1:0]  dc;
        logic        dr;
        logic        fl;
        logic [1:0]  fc;
        int          d;
        logic        x_rdy;
        logic        x_val;
        logic [31:0] x_msg;
        int          fch;
        logic [31:0] x_free;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic ev, input logic [1:0] ec, input logic [31:0] em,
                       input logic [1:0] dc, input logic dr, input logic fl, input logic [1:0] fc,
                       input int d, input logic xr, input logic xv, input logic [31:0] xm,
                       input int fch, input logic [31:0] xf);
        vec_t v;
        v.rst = rst; v.ev = ev; v.ec = ec; v.em = em; v.dc = dc; v.dr = dr; v.fl = fl; v.fc = fc;
        v.d = d; v.x_rdy = xr; v.x_val = xv; v.x_msg = xm; v.fch = fch; v.x_free = xf;
        tbl.push_back(v);
    endtask

    initial begin
        // reset held, then fill channel 0, probe channel 1, drain, out-of-range indices
        add(0, 1, 0, 32'h0,  0, 0, 0, 0,  0, 0, 0, 32'h0,  0, 4);
        add(0, 1, 0, 32'h0,  0, 1, 0, 0,  1, 0, 0, 32'h0,  0, 4);
        add(1, 1, 0, 32'hA0, 1, 0, 0, 0,  0, 1, 0, 32'h0,  0, 4);
        add(1, 1, 0, 32'hA1, 1, 0, 0, 0,  0, 1, 0, 32'h0,  0, 3);
        add(1, 1, 0, 32'hA2, 1, 0, 0, 0,  0, 1, 0, 32'h0,  0, 2);
        add(1, 1, 0, 32'hA3, 1, 0, 0, 0,  0, 1, 0, 32'h0,  0, 1);
        add(1, 1, 0, 32'hA4, 1, 0, 0, 0,  0, 0, 0, 32'h0,  0, 0);
        add(1, 0, 1, 32'h0,  1, 0, 0, 0,  0, 1, 0, 32'h0,  1, 4);
        add(1, 0, 1, 32'h0,  0, 1, 0, 0,  0, 1, 1, 32'hA0, 0, 0);
        add(1, 0, 1, 32'h0,  0, 1, 0, 0,  0, 1, 1, 32'hA1, 0, 1);
        add(1, 0, 1, 32'h0,  0, 1, 0, 0,  0, 1, 1, 32'hA2, 0, 2);
        add(1, 0, 1, 32'h0,  0, 1, 0, 0,  0, 1, 1, 32'hA3, 0, 3);
        add(1, 0, 1, 32'h0,  0, 1, 0, 0,  0, 1, 0, 32'h0,  0, 4);
        add(1, 1, 3, 32'h55, 3, 1, 1, 3,  1, 0, 0, 32'h0,  0, 4);

        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            set_in(tbl[i].ev, tbl[i].ec, tbl[i].em, tbl[i].dc, tbl[i].dr, tbl[i].fl, tbl[i].fc);
            chk($sformatf("vec%0d enq_rdy", i), 32'(rdy_o[tbl[i].d]), 32'(tbl[i].x_rdy));
            chk($sformatf("vec%0d deq_val", i), 32'(val_o[tbl[i].d]), 32'(tbl[i].x_val));
            chk($sformatf("vec%0d deq_msg", i), msg_o[tbl[i].d], tbl[i].x_msg);
            chk($sformatf("vec%0d free", i), fr(tbl[i].d, tbl[i].fch), tbl[i].x_free);
            tick();
        end

        // PIPE vs NORMAL with channel 0 full and a same-cycle dequeue
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 32'hB0 + 32'(i), 2, 0, 0, 0);
            tick();
        end
        set_in(1, 0, 32'hB4, 0, 1, 0, 0);
        chk("pipe enq_rdy", 32'(rdy_o[1]), 1);
        chk("pipe deq_val", 32'(val_o[1]), 1);
        chk("pipe deq_msg", msg_o[1], 32'hB0);
        chk("pipe free", fr(1, 0), 0);
        chk("normal full enq_rdy", 32'(rdy_o[0]), 0);
        chk("normal full deq_msg", msg_o[0], 32'hB0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("pipe free after", fr(1, 0), 0);
        chk("pipe head after", msg_o[1], 32'hB1);
        chk("normal free after", fr(0, 0), 1);

        // BYPASS on an empty channel
        apply_reset();
        set_in(1, 1, 32'hC1, 1, 1, 0, 0);
        chk("bypass deq_val", 32'(val_o[1]), 1);
        chk("bypass deq_msg", msg_o[1], 32'hC1);
        chk("bypass enq_rdy", 32'(rdy_o[1]), 1);
        chk("normal no bypass val", 32'(val_o[0]), 0);
        chk("normal no bypass msg", msg_o[0], 32'h0);
        tick();
        set_in(0, 1, 0, 1, 0, 0, 0);
        chk("bypass free after", fr(1, 1), 4);
        chk("bypass val after", 32'(val_o[1]), 0);
        chk("normal free after enq", fr(0, 1), 3);
        chk("normal latency msg", msg_o[0], 32'hC1);

        // flush of channel 0 while channel 1 holds data
        apply_reset();
        set_in(1, 0, 32'hD0, 2, 0, 0, 0); tick();
        set_in(1, 0, 32'hD1, 2, 0, 0, 0); tick();
        set_in(1, 1, 32'hE0, 2, 0, 0, 0); tick();
        set_in(1, 0, 32'hD2, 0, 0, 1, 0);
        chk("flush enq_rdy", 32'(rdy_o[0]), 0);
        chk("flush deq_val", 32'(val_o[0]), 0);
        chk("flush deq_val d1", 32'(val_o[1]), 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("flush free ch0", fr(0, 0), 4);
        chk("flush val ch0", 32'(val_o[0]), 0);
        chk("flush free ch1", fr(0, 1), 3);
        set_in(0, 0, 0, 1, 0, 0, 0);
        chk("flush ch1 intact", msg_o[0], 32'hE0);

        // wrap-around on the depth-3 configuration, channel 1
        apply_reset();
        for (int i = 0; i <= 10; i++) begin
            set_in(i < 10, 1, 32'hF0 + 32'(i), 1, i > 0, 0, 0);
            if (i > 0) begin
                chk($sformatf("wrap val %0d", i), 32'(val_o[2]), 1);
                chk($sformatf("wrap msg %0d", i), msg_o[2], 32'hF0 + 32'(i - 1));
                chk($sformatf("wrap free %0d", i), fr(2, 1), 2);
            end
            tick();
        end
        set_in(0, 1, 0, 1, 0, 0, 0);
        chk("wrap empty", 32'(val_o[2]), 0);
        chk("wrap free end", fr(2, 1), 3);
        tick();

        // randomized traffic against the queue model
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 39) != 0);
            set_in($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
